// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch requester (IF) and the
//   data requester (MEM). Each access is granted and the memory address,
//   write enable and write data are captured. The arbiter then waits for
//   mem_ack and pulses the owning side's done for one cycle. The 3-bit
//   per-side status codes drive the core's freeze logic.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog.
//   After TO_CYCLES request cycles without an ack it abandons the access,
//   sets sticky timeout_err and reports code 100.
//
// Ports
//   clk, rst                : clock (rising edge), async active-low reset
//   if_req/if_addr          : fetch request (level) and address
//   if_rdata/if_done        : fetched word, one-cycle completion pulse
//   d_read/d_write          : data request (level), write wins if both
//   d_addr/d_wdata          : data address and store data
//   d_rdata/d_done          : load data, one-cycle completion pulse
//   instr_state/mem_state   : per-side code 000 IDLE 001 WAIT 010 BUSY
//                             011 DONE 100 ERR
//   stall                   : any asserted request not yet done
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : memory port
//   timeout_err             : sticky watchdog error (0 without the macro)
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TO_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [2:0]        instr_state,
   output logic [2:0]        mem_state,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_GNT_I, S_GNT_D, S_DONE} state_t;

   state_t            r_state;
   logic              r_last_d;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_done;
   logic              r_d_done;
   logic              w_d_req;
   logic              w_to_flag;
   logic [2:0]        w_instr_state;
   logic [2:0]        w_mem_state;

   assign w_d_req = d_read | d_write;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_to_done;
   logic             r_timeout_err;
   assign w_to_flag   = r_to_done;
   assign timeout_err = r_timeout_err;
`else
   // TO_CYCLES only matters when the watchdog is built in
   logic w_unused_to_cycles;
   assign w_unused_to_cycles = (TO_CYCLES > 0);
   assign w_to_flag   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_last_d    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_if_done   <= 1'b0;
         r_d_done    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         r_cnt         <= '0;
         r_to_done     <= 1'b0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_if_done <= 1'b0;
         r_d_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // data first, unless a fetch is waiting behind the last data access
               if (w_d_req && (!if_req || !r_last_d)) begin
                  r_state     <= S_GNT_D;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_write;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
               end else if (if_req) begin
                  r_state     <= S_GNT_I;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wdata <= '0;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               r_cnt <= '0;
`endif
            end
            S_GNT_I, S_GNT_D: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_DONE;
                  r_last_d  <= (r_state == S_GNT_D);
                  if (r_state == S_GNT_D) begin
                     r_d_done <= 1'b1;
                     if (!r_mem_we) r_d_rdata <= mem_rdata;
                  end else begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (r_cnt == CNT_W'(TO_CYCLES - 1)) begin
                  r_mem_req     <= 1'b0;
                  r_state       <= S_DONE;
                  r_to_done     <= 1'b1;
                  r_timeout_err <= 1'b1;
                  if (r_state == S_GNT_D) begin
                     r_d_done  <= 1'b1;
                     r_d_rdata <= '0;
                  end else begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            default: begin
               r_state <= S_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
               r_to_done <= 1'b0;
`endif
            end
         endcase
      end
   end

   // Status codes are decoded from the registered FSM plus the live
   // request levels so a requester sees WAIT in the cycle it asks.
   always_comb begin
      w_instr_state = 3'b000;
      w_mem_state   = 3'b000;
      if (rst) begin
         if (r_state == S_GNT_I)                   w_instr_state = 3'b010;
         else if (r_state == S_DONE && r_if_done)  w_instr_state = w_to_flag ? 3'b100 : 3'b011;
         else if (if_req)                          w_instr_state = 3'b001;

         if (r_state == S_GNT_D)                   w_mem_state = 3'b010;
         else if (r_state == S_DONE && r_d_done)   w_mem_state = w_to_flag ? 3'b100 : 3'b011;
         else if (w_d_req)                         w_mem_state = 3'b001;
      end
   end

   assign instr_state = w_instr_state;
   assign mem_state   = w_mem_state;
   assign stall       = rst & ((if_req & ~r_if_done) | (w_d_req & ~r_d_done));
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign if_rdata    = r_if_rdata;
   assign d_rdata     = r_d_rdata;
   assign if_done     = r_if_done;
   assign d_done      = r_d_done;

endmodule
